// File: rtl/axis_rx_pkg.sv
// axis_rx_pkg
// Shared definitions for the AXI4-Stream receive checker:
//   - bit positions inside rpt_err
//   - receive FSM state encoding
//   - report record at the default field widths (W_LEN=16, W_USER=16)
//   - polynomial and seed of the optional backpressure LFSR
package axis_rx_pkg;

    localparam int unsigned ERR_KEEP_ZERO = 0;  // beat with no valid bytes
    localparam int unsigned ERR_KEEP_GAP  = 1;  // tkeep not of the form 2^n-1
    localparam int unsigned ERR_KEEP_MID  = 2;  // partial tkeep on a non-last beat
    localparam int unsigned ERR_USER_SIZE = 3;  // tuser changed or packet oversize

    typedef enum logic {
        S_FIRST = 1'b0,
        S_BODY  = 1'b1
    } rx_state_t;

    localparam int unsigned RPT_W_LEN  = 16;
    localparam int unsigned RPT_W_USER = 16;

    // Report record for the default widths; the checker itself is
    // width-parameterised and keeps its report fields in separate registers.
    typedef struct packed {
        logic [RPT_W_LEN-1:0]  bytes;
        logic [RPT_W_LEN-1:0]  beats;
        logic [RPT_W_USER-1:0] user;
        logic [3:0]            err;
    } rpt_t;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_POLY = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/axis_rx_checker_if.sv
// axis_rx_checker_if
// AXI4-Stream beat bus carried into the receive checker.
//   tvalid/tready : beat handshake
//   tdata         : W_DATA bits of payload
//   tkeep         : W_DATA/8 byte enables
//   tlast         : last beat of packet
//   tuser         : W_USER bits of per-packet sideband
// Modports: master (stream source), slave (stream sink).
interface axis_rx_checker_if #(
    parameter int unsigned W_DATA = 512,
    parameter int unsigned W_USER = 16
);
    localparam int unsigned W_KEEP = W_DATA / 8;

    logic              tvalid;
    logic              tready;
    logic [W_DATA-1:0] tdata;
    logic [W_KEEP-1:0] tkeep;
    logic              tlast;
    logic [W_USER-1:0] tuser;

    modport master (
        output tvalid, tdata, tkeep, tlast, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tlast, tuser,
        output tready
    );
endinterface

// File: rtl/axis_keep_decode.sv
// axis_keep_decode
// Combinational tkeep decode.
//   keep     in  W_KEEP  byte enables of one beat
//   count    out         number of set bits, width $clog2(W_KEEP+1)
//   zero     out         no byte enabled
//   contig   out         keep == 2^n-1 (LSB-aligned, no holes; zero counts)
//   all_ones out         every byte enabled
module axis_keep_decode #(
    parameter int unsigned W_KEEP = 64,
    parameter int unsigned W_CNT  = $clog2(W_KEEP + 1)
) (
    input  logic [W_KEEP-1:0] keep,
    output logic [W_CNT-1:0]  count,
    output logic              zero,
    output logic              contig,
    output logic              all_ones
);

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < W_KEEP; i++) begin
            count = count + W_CNT'(keep[i]);
        end
    end

    // A mask of the form 2^n-1 has no bit in common with itself plus one.
    logic [W_KEEP-1:0] keep_inc;
    assign keep_inc = keep + W_KEEP'(1);
    assign contig   = ((keep & keep_inc) == '0);
    assign zero     = (keep == '0);
    assign all_ones = &keep;

endmodule

// File: rtl/axis_rx_checker.sv
// axis_rx_checker
// AXI4-Stream receive-end checker: accepts beats, measures each packet
// (beats, bytes from tkeep), validates tkeep/tuser framing and publishes one
// report per packet on a valid/ready side channel, plus free-running counters.
//   clk, rst         single clock, synchronous active-high reset
//   s_axis           slave stream (axis_rx_checker_if.slave)
//   bp_thresh        throttle level, 0 = never throttle
//   rpt_valid/ready  report handshake
//   rpt_bytes/beats  saturating totals of the reported packet
//   rpt_user         tuser of the packet's first beat
//   rpt_err          [0] keep_zero [1] keep_gap [2] keep_mid_partial
//                    [3] user_change_or_oversize
//   cnt_pkts/errs    completed packets / packets with any error (wrap)
// Build option: define AXIS_RX_BACKPRESSURE_EN to throttle tready from a
// 16-bit LFSR compared against bp_thresh; otherwise bp_thresh is ignored.
module axis_rx_checker
    import axis_rx_pkg::*;
#(
    parameter int unsigned W_DATA    = 512,
    parameter int unsigned W_USER    = 16,
    parameter int unsigned W_LEN     = 16,
    parameter int unsigned MAX_BYTES = 9600
) (
    input  logic                   clk,
    input  logic                   rst,
    axis_rx_checker_if.slave       s_axis,
    input  logic [3:0]             bp_thresh,
    output logic                   rpt_valid,
    input  logic                   rpt_ready,
    output logic [W_LEN-1:0]       rpt_bytes,
    output logic [W_LEN-1:0]       rpt_beats,
    output logic [W_USER-1:0]      rpt_user,
    output logic [3:0]             rpt_err,
    output logic [31:0]            cnt_pkts,
    output logic [31:0]            cnt_errs
);

    localparam int unsigned W_KEEP = W_DATA / 8;
    localparam int unsigned W_CNT  = $clog2(W_KEEP + 1);
    localparam int unsigned W_SUM  = W_LEN + 1;

    rx_state_t         state, state_nxt;
    logic [W_LEN-1:0]  acc_bytes, acc_beats;
    logic [W_USER-1:0] acc_user;
    logic [3:0]        acc_err;

    logic [W_SUM-1:0]  bytes_sum, beats_sum;
    logic [W_LEN-1:0]  bytes_nxt, beats_nxt;
    logic [W_USER-1:0] user_nxt;
    logic [3:0]        err_nxt;
    logic              first;
    logic              fire;
    logic              bp_ok;

    logic [W_CNT-1:0]  kd_count;
    logic              kd_zero, kd_contig, kd_all_ones;

    axis_keep_decode #(
        .W_KEEP (W_KEEP),
        .W_CNT  (W_CNT)
    ) u_keep_decode (
        .keep     (s_axis.tkeep),
        .count    (kd_count),
        .zero     (kd_zero),
        .contig   (kd_contig),
        .all_ones (kd_all_ones)
    );

`ifdef AXIS_RX_BACKPRESSURE_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_POLY : 16'h0000);
        end
    end

    assign bp_ok = (lfsr[3:0] >= bp_thresh);

    logic unused_ok;
    assign unused_ok = ^s_axis.tdata;
`else
    assign bp_ok = 1'b1;

    logic unused_ok;
    assign unused_ok = (^s_axis.tdata) ^ (^bp_thresh);
`endif

    // A full, unconsumed report slot stalls the stream; a same-cycle pop
    // frees the slot so the next tlast may overwrite it.
    assign s_axis.tready = !rst && !(rpt_valid && !rpt_ready) && bp_ok;
    assign fire          = s_axis.tvalid && s_axis.tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FIRST;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and the packet totals as they stand after the current beat.
    always_comb begin
        state_nxt = state;
        first     = (state == S_FIRST);

        bytes_sum = (first ? '0 : W_SUM'(acc_bytes)) + W_SUM'(kd_count);
        beats_sum = (first ? '0 : W_SUM'(acc_beats)) + W_SUM'(1);
        bytes_nxt = bytes_sum[W_LEN] ? '1 : bytes_sum[W_LEN-1:0];
        beats_nxt = beats_sum[W_LEN] ? '1 : beats_sum[W_LEN-1:0];
        user_nxt  = first ? s_axis.tuser : acc_user;

        err_nxt = first ? 4'b0000 : acc_err;
        err_nxt[ERR_KEEP_ZERO] = err_nxt[ERR_KEEP_ZERO] | kd_zero;
        err_nxt[ERR_KEEP_GAP]  = err_nxt[ERR_KEEP_GAP]  | !kd_contig;
        err_nxt[ERR_KEEP_MID]  = err_nxt[ERR_KEEP_MID]  | (!s_axis.tlast && !kd_all_ones);
        err_nxt[ERR_USER_SIZE] = err_nxt[ERR_USER_SIZE]
                               | (!first && (s_axis.tuser != acc_user))
                               | (bytes_sum > W_SUM'(MAX_BYTES));

        if (fire) begin
            state_nxt = s_axis.tlast ? S_FIRST : S_BODY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_bytes <= '0;
            acc_beats <= '0;
            acc_user  <= '0;
            acc_err   <= '0;
            rpt_valid <= 1'b0;
            rpt_bytes <= '0;
            rpt_beats <= '0;
            rpt_user  <= '0;
            rpt_err   <= '0;
            cnt_pkts  <= '0;
            cnt_errs  <= '0;
        end else begin
            if (fire) begin
                acc_bytes <= bytes_nxt;
                acc_beats <= beats_nxt;
                acc_user  <= user_nxt;
                acc_err   <= err_nxt;
            end
            if (fire && s_axis.tlast) begin
                rpt_valid <= 1'b1;
                rpt_bytes <= bytes_nxt;
                rpt_beats <= beats_nxt;
                rpt_user  <= user_nxt;
                rpt_err   <= err_nxt;
                cnt_pkts  <= cnt_pkts + 32'd1;
                if (|err_nxt) begin
                    cnt_errs <= cnt_errs + 32'd1;
                end
            end else if (rpt_valid && rpt_ready) begin
                rpt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_rx_checker.sv
// tb_axis_rx_checker
// Self-checking bench for axis_rx_checker: table of packets with hand-derived
// reports, hand-written stall/reset sequences and a random phase checked
// against a behavioural model through a report scoreboard.
module tb_axis_rx_checker;
    import axis_rx_pkg::*;

    localparam int unsigned W_DATA    = 512;
    localparam int unsigned W_USER    = 16;
    localparam int unsigned W_LEN     = 16;
    localparam int unsigned MAX_BYTES = 9600;
    localparam logic [63:0] ONES      = '1;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  bp_thresh;
    logic        rpt_valid;
    logic        rpt_ready;
    logic [15:0] rpt_bytes;
    logic [15:0] rpt_beats;
    logic [15:0] rpt_user;
    logic [3:0]  rpt_err;
    logic [31:0] cnt_pkts;
    logic [31:0] cnt_errs;

    axis_rx_checker_if #(.W_DATA(W_DATA), .W_USER(W_USER)) axis ();

    axis_rx_checker #(
        .W_DATA    (W_DATA),
        .W_USER    (W_USER),
        .W_LEN     (W_LEN),
        .MAX_BYTES (MAX_BYTES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_axis    (axis),
        .bp_thresh (bp_thresh),
        .rpt_valid (rpt_valid),
        .rpt_ready (rpt_ready),
        .rpt_bytes (rpt_bytes),
        .rpt_beats (rpt_beats),
        .rpt_user  (rpt_user),
        .rpt_err   (rpt_err),
        .cnt_pkts  (cnt_pkts),
        .cnt_errs  (cnt_errs)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    rpt_t sb[$];
    int   popped      = 0;
    int   popped_errs = 0;
    int   seen_bytes  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Report monitor: a handshake visible at the falling edge completes on
    // the next rising edge, so the report is compared and retired here.
    always @(negedge clk) begin
        rpt_t e;
        if (rst === 1'b0 && rpt_valid === 1'b1 && rpt_ready === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected_report: got bytes=%0d beats=%0d expected no report",
                         rpt_bytes, rpt_beats);
            end else begin
                e = sb.pop_front();
                chk("rpt_bytes", 32'(rpt_bytes), 32'(e.bytes));
                chk("rpt_beats", 32'(rpt_beats), 32'(e.beats));
                chk("rpt_user",  32'(rpt_user),  32'(e.user));
                chk("rpt_err",   32'(rpt_err),   32'(e.err));
                popped++;
                if (e.err != 4'b0000) popped_errs++;
                chk("cnt_pkts", cnt_pkts, 32'(popped));
                chk("cnt_errs", cnt_errs, 32'(popped_errs));
                seen_bytes += int'(rpt_bytes);
            end
        end
    end

    task automatic push(input int unsigned bytes, input int unsigned beats,
                        input logic [15:0] user, input logic [3:0] err);
        rpt_t e;
        e.bytes = 16'(bytes);
        e.beats = 16'(beats);
        e.user  = user;
        e.err   = err;
        sb.push_back(e);
    endtask

    // Drive one beat from just after a rising edge and hold it until accepted.
    task automatic send_beat(input logic [63:0] keep, input logic last, input logic [15:0] user);
        int unsigned waited = 0;
        axis.tvalid = 1'b1;
        axis.tkeep  = keep;
        axis.tlast  = last;
        axis.tuser  = user;
        axis.tdata  = {16{$urandom()}};
        forever begin
            @(negedge clk);
            if (axis.tready === 1'b1) break;
            waited++;
            if (waited > 500) begin
                total++;
                bad++;
                $display("FAIL beat_accept_timeout: got tready=0 for %0d cycles expected acceptance", waited);
                break;
            end
        end
        @(posedge clk);
        #1;
        axis.tvalid = 1'b0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);
    endtask

    typedef struct {
        int unsigned nb;
        logic [63:0] kf, km, kl;
        logic [15:0] u, um;
        int unsigned eb, ebt;
        logic [3:0]  ee;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned duty;
        logic        duty_ok;
        int          exp_bytes_total;
        logic        rnd_done;

        tbl[0] = '{3,   ONES,      ONES,  64'hFF, 16'h00A5, 16'h00A5, 136,  3,   4'b0000};
        tbl[1] = '{1,   64'h0F0F,  ONES,  ONES,   16'h0001, 16'h0001, 8,    1,   4'b0010};
        tbl[2] = '{3,   ONES,      64'hFF, ONES,  16'h0011, 16'h0022, 136,  3,   4'b1100};
        tbl[3] = '{1,   64'h0,     ONES,  ONES,   16'h0003, 16'h0003, 0,    1,   4'b0001};
        tbl[4] = '{2,   ONES,      ONES,  64'hF0, 16'h0004, 16'h0004, 68,   2,   4'b0010};
        tbl[5] = '{150, ONES,      ONES,  ONES,   16'h0005, 16'h0005, 9600, 150, 4'b0000};
        tbl[6] = '{151, ONES,      ONES,  ONES,   16'h0006, 16'h0006, 9664, 151, 4'b1000};
        tbl[7] = '{2,   64'h7,     ONES,  ONES,   16'h0007, 16'h0007, 67,   2,   4'b0100};

        rst         = 1'b1;
        bp_thresh   = 4'd0;
        rpt_ready   = 1'b1;
        axis.tvalid = 1'b0;
        axis.tkeep  = '0;
        axis.tlast  = 1'b0;
        axis.tuser  = '0;
        axis.tdata  = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tready_low", 32'(axis.tready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rpt_valid", 32'(rpt_valid), 32'd0);
        chk("rst_rpt_bytes", 32'(rpt_bytes), 32'd0);
        chk("rst_rpt_beats", 32'(rpt_beats), 32'd0);
        chk("rst_rpt_user",  32'(rpt_user),  32'd0);
        chk("rst_rpt_err",   32'(rpt_err),   32'd0);
        chk("rst_cnt_pkts",  cnt_pkts, 32'd0);
        chk("rst_cnt_errs",  cnt_errs, 32'd0);
        chk("rst_tready_after", 32'(axis.tready), 32'd1);
        @(posedge clk);
        #1;

        // Table-driven packets.
        for (int unsigned i = 0; i < 8; i++) begin
            push(tbl[i].eb, tbl[i].ebt, tbl[i].u, tbl[i].ee);
            for (int unsigned b = 0; b < tbl[i].nb; b++) begin
                logic        last;
                logic [63:0] k;
                logic [15:0] usr;
                last = (b == tbl[i].nb - 1);
                k    = (b == 0) ? tbl[i].kf : (last ? tbl[i].kl : tbl[i].km);
                usr  = (b == 0 || last) ? tbl[i].u : tbl[i].um;
                send_beat(k, last, usr);
            end
        end
        drain();

        // Report slot full: second packet stalls until the first report is taken.
        rpt_ready = 1'b0;
        push(8, 1, 16'h0031, 4'b0000);
        push(4, 1, 16'h0032, 4'b0000);
        send_beat(64'hFF, 1'b1, 16'h0031);
        fork
            send_beat(64'hF, 1'b1, 16'h0032);
            begin
                for (int unsigned c = 0; c < 6; c++) begin
                    @(negedge clk);
                    chk("stall_tready", 32'(axis.tready), 32'd0);
                    chk("stall_rpt_bytes", 32'(rpt_bytes), 32'd8);
                end
                @(posedge clk);
                #1;
                rpt_ready = 1'b1;
            end
        join
        drain();

        // Reset during beat 2 of 4: the partial packet leaves no report.
        send_beat(ONES, 1'b0, 16'h0040);
        axis.tvalid = 1'b1;
        axis.tkeep  = ONES;
        axis.tlast  = 1'b0;
        rst         = 1'b1;
        @(negedge clk);
        chk("midrst_tready", 32'(axis.tready), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst         = 1'b0;
        axis.tvalid = 1'b0;
        popped      = 0;
        popped_errs = 0;
        @(negedge clk);
        chk("midrst_rpt_valid", 32'(rpt_valid), 32'd0);
        chk("midrst_cnt_pkts",  cnt_pkts, 32'd0);
        @(posedge clk);
        #1;
        push(2, 1, 16'h0041, 4'b0000);
        send_beat(64'h3, 1'b1, 16'h0041);
        drain();
        chk("midrst_cnt_final", cnt_pkts, 32'd1);

        // Throttle duty with an idle report slot.
        bp_thresh = 4'd8;
        duty = 0;
        for (int unsigned c = 0; c < 400; c++) begin
            @(negedge clk);
            if (axis.tready === 1'b1) duty++;
        end
`ifdef AXIS_RX_BACKPRESSURE_EN
        duty_ok = (duty >= 120 && duty <= 280);
        chk("bp_duty_near_half", 32'(duty_ok), 32'd1);
`else
        duty_ok = (duty == 400);
        chk("bp_duty_unthrottled", 32'(duty_ok), 32'd1);
`endif
        @(posedge clk);
        #1;

        // Random packets against the behavioural model, random report consumer.
        exp_bytes_total = 0;
        seen_bytes      = 0;
        rnd_done        = 1'b0;
        fork
            begin
                for (int unsigned p = 0; p < 300; p++) begin
                    int unsigned n;
                    int unsigned bytes;
                    logic [3:0]  err;
                    logic [15:0] u;
                    logic [63:0] ks[6];
                    n     = $urandom_range(1, 6);
                    u     = 16'($urandom());
                    bytes = 0;
                    err   = 4'b0000;
                    for (int unsigned b = 0; b < n; b++) begin
                        logic [63:0] k;
                        logic [63:0] ref_mask;
                        int unsigned pc;
                        case ($urandom_range(0, 7))
                            0:       k = {$urandom(), $urandom()};
                            1, 2:    k = ONES >> $urandom_range(0, 64);
                            default: k = ONES;
                        endcase
                        pc       = $countones(k);
                        ref_mask = (pc == 0) ? 64'h0 : (ONES >> (64 - pc));
                        bytes   += pc;
                        if (pc == 0) err[0] = 1'b1;
                        if (k != ref_mask) err[1] = 1'b1;
                        if (b != n - 1 && pc != 64) err[2] = 1'b1;
                        ks[b] = k;
                    end
                    if (bytes > MAX_BYTES) err[3] = 1'b1;
                    exp_bytes_total += int'(bytes);
                    push(bytes, n, u, err);
                    for (int unsigned b = 0; b < n; b++) begin
                        send_beat(ks[b], (b == n - 1), u);
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    rpt_ready = ($urandom_range(0, 3) != 0);
                end
                rpt_ready = 1'b1;
            end
        join
        drain();
        chk("rnd_byte_total", 32'(seen_bytes), 32'(exp_bytes_total));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
